// File: rtl/dmem_arbiter.sv
// Two-master arbiter in front of the single-port data memory.
// One outstanding transaction: IDLE grants, ACCESS drives dmem, RESP holds the response.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 11,
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_write,
  input  logic [31:0] m0_req_addr,
  input  logic [1:0]  m0_req_type,
  input  logic [31:0] m0_req_wdata,
  output logic        m0_resp_valid,
  input  logic        m0_resp_ready,
  output logic [31:0] m0_resp_rdata,
  output logic        m0_resp_error,
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_write,
  input  logic [31:0] m1_req_addr,
  input  logic [1:0]  m1_req_type,
  input  logic [31:0] m1_req_wdata,
  output logic        m1_resp_valid,
  input  logic        m1_resp_ready,
  output logic [31:0] m1_resp_rdata,
  output logic        m1_resp_error,
  output logic        mem_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_data_type,
  output logic [31:0] mem_input_data,
  input  logic [31:0] mem_output_data
);

  localparam int unsigned DW = 32;
  localparam int unsigned TW = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic            id_q, id_d;
  logic            wr_q, wr_d;
  logic [DW-1:0]   addr_q, addr_d;
  logic [TW-1:0]   type_q, type_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            err_q, err_d;

  logic            grant1_c;
  logic            acc_err_c;
  logic            mem_en_c;
  logic [DW-1:0]   load_data_c;

  // Master 1 wins when alone, or on a tie when the rotating pointer favours it.
  assign grant1_c  = m1_req_valid &&
                     (!m0_req_valid || ((ROUND_ROBIN != 0) && rr_q));
  assign acc_err_c = (type_q == 2'b11) || ((addr_q >> ADDR_WIDTH) != '0);

  always_comb begin
    load_data_c = '0;
    case (type_q)
      2'b00:   load_data_c = mem_output_data;
      2'b01:   load_data_c = {16'b0, mem_output_data[15:0]};
      2'b10:   load_data_c = {24'b0, mem_output_data[7:0]};
      default: load_data_c = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    id_d         = id_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    type_d       = type_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    mem_en_c     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m0_req_valid || m1_req_valid) begin
          m0_req_ready = !grant1_c;
          m1_req_ready = grant1_c;
          id_d    = grant1_c;
          wr_d    = grant1_c ? m1_req_write : m0_req_write;
          addr_d  = grant1_c ? m1_req_addr  : m0_req_addr;
          type_d  = grant1_c ? m1_req_type  : m0_req_type;
          wdata_d = grant1_c ? m1_req_wdata : m0_req_wdata;
          if (ROUND_ROBIN != 0) rr_d = !grant1_c;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_en_c = !acc_err_c;
        rdata_d  = (!wr_q && !acc_err_c) ? load_data_c : '0;
        err_d    = acc_err_c;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (id_q ? m1_resp_ready : m0_resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      id_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      type_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Enables are gated by reset_n so no negedge write can happen while reset is asserted.
  assign mem_enable       = mem_en_c && reset_n;
  assign mem_write_enable = mem_en_c && wr_q && reset_n;
  assign mem_address      = addr_q;
  assign mem_data_type    = type_q;
  assign mem_input_data   = wdata_q;

  assign m0_resp_valid = (state_q == ST_RESP) && !id_q;
  assign m1_resp_valid = (state_q == ST_RESP) && id_q;
  assign m0_resp_rdata = rdata_q;
  assign m1_resp_rdata = rdata_q;
  assign m0_resp_error = err_q;
  assign m1_resp_error = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: transaction-level reference model plus a
// behavioural dmem; a second fixed-priority instance checks the non-rotating grant rule.
module tb_dmem_arbiter;

  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct {bit wr; bit [31:0] addr; bit [1:0] typ; bit [31:0] wdata;} req_t;
  typedef struct {int m; bit [31:0] rdata; bit err;} rsp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, req_write, resp_valid, resp_ready, resp_error;
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  req_type [2];
  logic [31:0] m0_resp_rdata, m1_resp_rdata;
  logic        mem_enable, mem_write_enable;
  logic [31:0] mem_address, mem_input_data, mem_output_data;
  logic [1:0]  mem_data_type;

  logic [1:0]  fp_valid, fp_ready, fp_resp_valid, fp_resp_error;
  logic [31:0] fp_rdata0, fp_rdata1, fp_mem_addr, fp_mem_wdata;
  logic        fp_mem_en, fp_mem_we;
  logic [1:0]  fp_mem_type;

  bit [31:0] dmem [DEPTH];
  bit [31:0] ref_mem [DEPTH];

  int   ph;
  bit   mrr, mid;
  req_t cur;
  bit [31:0] exp_rdata;
  bit   exp_err;
  req_t mq0[$], mq1[$];
  rsp_t rsp_log[$];
  int   grant_log[$];
  bit   rnd_valid, rnd_ready, hold_low;
  int   en_count, checks, failures;

  always #5 clock = ~clock;

  assign mem_output_data = dmem[mem_address[AW-1:0]];

  dmem_arbiter #(.ADDR_WIDTH(AW), .ROUND_ROBIN(1)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_req_valid(req_valid[0]), .m0_req_ready(req_ready[0]), .m0_req_write(req_write[0]),
    .m0_req_addr(req_addr[0]), .m0_req_type(req_type[0]), .m0_req_wdata(req_wdata[0]),
    .m0_resp_valid(resp_valid[0]), .m0_resp_ready(resp_ready[0]),
    .m0_resp_rdata(m0_resp_rdata), .m0_resp_error(resp_error[0]),
    .m1_req_valid(req_valid[1]), .m1_req_ready(req_ready[1]), .m1_req_write(req_write[1]),
    .m1_req_addr(req_addr[1]), .m1_req_type(req_type[1]), .m1_req_wdata(req_wdata[1]),
    .m1_resp_valid(resp_valid[1]), .m1_resp_ready(resp_ready[1]),
    .m1_resp_rdata(m1_resp_rdata), .m1_resp_error(resp_error[1]),
    .mem_enable(mem_enable), .mem_write_enable(mem_write_enable), .mem_address(mem_address),
    .mem_data_type(mem_data_type), .mem_input_data(mem_input_data),
    .mem_output_data(mem_output_data)
  );

  dmem_arbiter #(.ADDR_WIDTH(AW), .ROUND_ROBIN(0)) dut_fp (
    .clock(clock), .reset_n(reset_n),
    .m0_req_valid(fp_valid[0]), .m0_req_ready(fp_ready[0]), .m0_req_write(1'b0),
    .m0_req_addr(32'd0), .m0_req_type(2'b00), .m0_req_wdata(32'd0),
    .m0_resp_valid(fp_resp_valid[0]), .m0_resp_ready(1'b1),
    .m0_resp_rdata(fp_rdata0), .m0_resp_error(fp_resp_error[0]),
    .m1_req_valid(fp_valid[1]), .m1_req_ready(fp_ready[1]), .m1_req_write(1'b0),
    .m1_req_addr(32'd1), .m1_req_type(2'b00), .m1_req_wdata(32'd0),
    .m1_resp_valid(fp_resp_valid[1]), .m1_resp_ready(1'b1),
    .m1_resp_rdata(fp_rdata1), .m1_resp_error(fp_resp_error[1]),
    .mem_enable(fp_mem_en), .mem_write_enable(fp_mem_we), .mem_address(fp_mem_addr),
    .mem_data_type(fp_mem_type), .mem_input_data(fp_mem_wdata),
    .mem_output_data(32'd0)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic req_t mk(bit wr, bit [31:0] a, bit [1:0] t, bit [31:0] d);
    req_t r;
    r.wr = wr; r.addr = a; r.typ = t; r.wdata = d;
    return r;
  endfunction

  // Sized load view and byte/half store merge, written as plain arithmetic.
  function automatic bit [31:0] size_load(bit [31:0] w, bit [1:0] t);
    if (t == 2'd1) return w % 65536;
    if (t == 2'd2) return w % 256;
    return w;
  endfunction

  function automatic bit [31:0] merge_store(bit [31:0] old, bit [31:0] d, bit [1:0] t);
    if (t == 2'd1) return (old - old % 65536) + d % 65536;
    if (t == 2'd2) return (old - old % 256) + d % 256;
    return d;
  endfunction

  function automatic rsp_t rsp_at(int i);
    rsp_t r;
    r.m = -1; r.rdata = 32'hBADBAD00; r.err = 1'b1;
    if (i < rsp_log.size()) r = rsp_log[i];
    return r;
  endfunction

  task automatic drive();
    req_t r;
    bit   have;
    for (int n = 0; n < 2; n++) begin
      have = (n == 0) ? (mq0.size() > 0) : (mq1.size() > 0);
      if (have) r = (n == 0) ? mq0[0] : mq1[0];
      if (reset_n && have && (!rnd_valid || ($urandom_range(0, 3) != 0))) begin
        req_valid[n] = 1'b1; req_write[n] = r.wr; req_addr[n] = r.addr;
        req_type[n] = r.typ; req_wdata[n] = r.wdata;
      end else begin
        req_valid[n] = 1'b0; req_write[n] = 1'($urandom); req_addr[n] = $urandom;
        req_type[n] = 2'($urandom); req_wdata[n] = $urandom;
      end
      resp_ready[n] = hold_low ? 1'b0 : (rnd_ready ? 1'($urandom) : 1'b1);
    end
  endtask

  // Compare DUT against the model for this cycle, then advance model and memory.
  task automatic sample();
    bit [1:0]  er;
    int        sel;
    bit        err_now, en_exp;
    bit [31:0] act;
    rsp_t      rs;
    if (!reset_n) begin
      check_eq("mem_enable_in_reset", 32'(mem_enable), 32'd0);
      check_eq("mem_we_in_reset", 32'(mem_write_enable), 32'd0);
      ph = 0; mrr = 1'b0;
      return;
    end
    er = 2'b00; sel = 0;
    if (ph == 0 && req_valid != 2'b00) begin
      sel = (req_valid == 2'b11) ? (mrr ? 1 : 0) : (req_valid[1] ? 1 : 0);
      er[sel] = 1'b1;
    end
    check_eq("m0_req_ready", 32'(req_ready[0]), 32'(er[0]));
    check_eq("m1_req_ready", 32'(req_ready[1]), 32'(er[1]));
    err_now = (cur.typ == 2'd3) || (cur.addr >= DEPTH);
    en_exp  = (ph == 1) && !err_now;
    check_eq("mem_enable", 32'(mem_enable), 32'(en_exp));
    check_eq("mem_write_enable", 32'(mem_write_enable), 32'(en_exp && cur.wr));
    if (en_exp) begin
      check_eq("mem_address", mem_address, cur.addr);
      check_eq("mem_data_type", 32'(mem_data_type), 32'(cur.typ));
      if (cur.wr) check_eq("mem_input_data", mem_input_data, cur.wdata);
    end
    if (mem_enable) en_count++;
    for (int n = 0; n < 2; n++)
      check_eq($sformatf("m%0d_resp_valid", n), 32'(resp_valid[n]),
               32'(ph == 2 && int'(mid) == n));
    act = mid ? m1_resp_rdata : m0_resp_rdata;
    if (ph == 2) begin
      check_eq("resp_rdata", act, exp_rdata);
      check_eq("resp_error", 32'(resp_error[mid]), 32'(exp_err));
    end
    if (mem_enable && mem_write_enable)
      dmem[mem_address[AW-1:0]] = merge_store(dmem[mem_address[AW-1:0]], mem_input_data,
                                              mem_data_type);
    for (int n = 0; n < 2; n++)
      if (req_valid[n] && req_ready[n]) grant_log.push_back(n);
    case (ph)
      0: if (er != 2'b00) begin
        if (sel == 1) cur = mq1.pop_front(); else cur = mq0.pop_front();
        mid = (sel == 1); mrr = (sel == 0); ph = 1;
      end
      1: begin
        exp_err = err_now; exp_rdata = 32'd0;
        if (!err_now) begin
          if (cur.wr) ref_mem[cur.addr[AW-1:0]] =
                        merge_store(ref_mem[cur.addr[AW-1:0]], cur.wdata, cur.typ);
          else exp_rdata = size_load(ref_mem[cur.addr[AW-1:0]], cur.typ);
        end
        ph = 2;
      end
      default: if (resp_ready[mid]) begin
        rs.m = int'(mid); rs.rdata = act; rs.err = resp_error[mid];
        rsp_log.push_back(rs);
        ph = 0;
      end
    endcase
  endtask

  task automatic step();
    drive();
    @(negedge clock);
    sample();
    @(posedge clock);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  function automatic bit [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return 32'h800 + $urandom_range(0, 63);
    if (k == 1) return $urandom;
    return $urandom_range(0, 15);
  endfunction

  function automatic req_t rand_req();
    return mk(1'($urandom), rand_addr(),
              ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)), $urandom);
  endfunction

  initial begin
    int c0, c1;
    rsp_t r;
    checks = 0; failures = 0; ph = 0; mrr = 1'b0; mid = 1'b0;
    cur = mk(1'b0, 32'd0, 2'd0, 32'd0);
    exp_rdata = 32'd0; exp_err = 1'b0;
    rnd_valid = 1'b0; rnd_ready = 1'b0; hold_low = 1'b0; en_count = 0;
    reset_n = 1'b0; fp_valid = 2'b00;
    for (int i = 0; i < int'(DEPTH); i++) begin
      dmem[i] = 32'(i) * 32'h9E3779B1;
      ref_mem[i] = dmem[i];
    end
    dmem[3] = 32'hCAFEF00D; ref_mem[3] = 32'hCAFEF00D;
    dmem[7] = 32'h11223344; ref_mem[7] = 32'h11223344;
    dmem[9] = 32'h01020304; ref_mem[9] = 32'h01020304;
    @(posedge clock); #1;
    run(2);
    reset_n = 1'b1;
    run(1);
    check_eq("reset_m0_rdata", m0_resp_rdata, 32'd0);
    check_eq("reset_m1_rdata", m1_resp_rdata, 32'd0);
    check_eq("reset_resp_error", 32'(resp_error), 32'd0);

    // Both masters busy: grants must alternate starting with master 0.
    for (int i = 0; i < 3; i++) begin
      mq0.push_back(mk(1'b0, 32'(20 + i), 2'd0, 32'd0));
      mq1.push_back(mk(1'b0, 32'(30 + i), 2'd0, 32'd0));
    end
    run(24);
    check_eq("rr_grant_count", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < grant_log.size(); i++)
      check_eq($sformatf("rr_grant_%0d", i), 32'(grant_log[i]), 32'(i % 2));

    rsp_log.delete();
    mq0.push_back(mk(1'b1, 32'd5, 2'd0, 32'hDEADBEEF));
    mq0.push_back(mk(1'b0, 32'd5, 2'd0, 32'd0));
    run(10);
    r = rsp_at(0); check_eq("store_word_rdata", r.rdata, 32'd0);
    r = rsp_at(1); check_eq("load_word_rdata", r.rdata, 32'hDEADBEEF);
    check_eq("load_word_error", 32'(r.err), 32'd0);

    rsp_log.delete();
    mq0.push_back(mk(1'b1, 32'd7, 2'd2, 32'hCCDDEEAB));
    mq0.push_back(mk(1'b0, 32'd7, 2'd2, 32'd0));
    mq0.push_back(mk(1'b0, 32'd7, 2'd0, 32'd0));
    mq0.push_back(mk(1'b0, 32'd7, 2'd1, 32'd0));
    run(16);
    r = rsp_at(1); check_eq("load_byte_rdata", r.rdata, 32'h000000AB);
    r = rsp_at(2); check_eq("load_word_merged", r.rdata, 32'h112233AB);
    r = rsp_at(3); check_eq("load_half_rdata", r.rdata, 32'h000033AB);

    rsp_log.delete(); en_count = 0;
    mq0.push_back(mk(1'b1, 32'd3, 2'd3, 32'h12345678));
    mq0.push_back(mk(1'b0, 32'h800, 2'd0, 32'd0));
    run(8);
    check_eq("err_mem_enable_count", 32'(en_count), 32'd0);
    r = rsp_at(0); check_eq("illegal_type_error", 32'(r.err), 32'd1);
    check_eq("illegal_type_rdata", r.rdata, 32'd0);
    r = rsp_at(1); check_eq("out_of_range_error", 32'(r.err), 32'd1);
    check_eq("out_of_range_rdata", r.rdata, 32'd0);
    check_eq("word3_unchanged", dmem[3], 32'hCAFEF00D);

    rsp_log.delete(); hold_low = 1'b1;
    mq0.push_back(mk(1'b0, 32'd7, 2'd0, 32'd0));
    mq1.push_back(mk(1'b0, 32'd5, 2'd0, 32'd0));
    run(6);
    check_eq("held_resp_valid", 32'(resp_valid != 2'b00), 32'd1);
    check_eq("held_no_consume", 32'(rsp_log.size()), 32'd0);
    hold_low = 1'b0;
    run(10);
    check_eq("held_resp_count", 32'(rsp_log.size()), 32'd2);
    for (int i = 0; i < rsp_log.size(); i++)
      check_eq("held_rdata", rsp_log[i].rdata, (rsp_log[i].m == 0) ? 32'h112233AB : 32'hDEADBEEF);

    mq0.push_back(mk(1'b1, 32'd9, 2'd0, 32'h00000055));
    run(1);
    reset_n = 1'b0;
    run(1);
    reset_n = 1'b1;
    rsp_log.delete();
    run(5);
    check_eq("reset_drop_no_resp", 32'(rsp_log.size()), 32'd0);
    check_eq("reset_drop_mem", dmem[9], 32'h01020304);

    rnd_valid = 1'b1; rnd_ready = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (mq0.size() == 0 && $urandom_range(0, 1) == 1) mq0.push_back(rand_req());
      if (mq1.size() == 0 && $urandom_range(0, 1) == 1) mq1.push_back(rand_req());
      step();
    end
    rnd_valid = 1'b0;
    run(30);
    check_eq("queues_drained", 32'(mq0.size() + mq1.size()), 32'd0);
    for (int i = 0; i < 16; i++)
      check_eq($sformatf("final_mem_%0d", i), dmem[i], ref_mem[i]);

    // Fixed priority: master 1 only gets through once master 0 stops asking.
    c0 = 0; c1 = 0; fp_valid = 2'b11;
    repeat (12) begin
      @(negedge clock);
      if (fp_valid[0] && fp_ready[0]) c0++;
      if (fp_valid[1] && fp_ready[1]) c1++;
      @(posedge clock); #1;
    end
    check_eq("fp_m0_grants", 32'(c0), 32'd4);
    check_eq("fp_m1_starved", 32'(c1), 32'd0);
    c0 = 0; c1 = 0; fp_valid = 2'b10;
    repeat (9) begin
      @(negedge clock);
      if (fp_valid[0] && fp_ready[0]) c0++;
      if (fp_valid[1] && fp_ready[1]) c1++;
      @(posedge clock); #1;
    end
    check_eq("fp_m1_grants", 32'(c1), 32'd3);
    fp_valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
